// File: rtl/decode_pipe.sv
// decode_pipe: decode stage with write-through register file, hazard stalls,
// decode-time branch/jump resolution with MEM forwarding, and the ID/EX register.
module decode_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   PCPlus1,
    input  logic              stall_in,
    output logic              id_ready,
    input  logic              wb_we,
    input  logic              wb_jal,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_target,
    output logic              ex_valid,
    output logic              ex_RegWriteEn,
    output logic              ex_MemReadEn,
    output logic              ex_MemWriteEn,
    output logic              ex_MemtoReg,
    output logic              ex_ALUSrc,
    output logic              ex_jal,
    output logic [3:0]        ex_ALUOp,
    output logic [DATA_W-1:0] ex_readData1,
    output logic [DATA_W-1:0] ex_readData2,
    output logic [DATA_W-1:0] ex_extImm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dest,
    output logic [4:0]        ex_shamt,
    output logic [PC_W-1:0]   ex_pcplus1,
    output logic [15:0]       stall_count
);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, FN_JR = 6'h08;

    logic [DATA_W-1:0] r_regs [2**REG_AW];

    logic [5:0]        w_op, w_fn;
    logic [4:0]        w_rs5, w_rt5, w_rd5;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dest, w_waddr;
    logic [DATA_W-1:0] w_imm, w_rf1, w_rf2, w_fwd1, w_fwd2;
    logic [3:0]        w_aluop, w_r_aluop, w_i_aluop;
    logic w_rw, w_mr, w_mw, w_m2r, w_src, w_jal, w_jmp, w_jr, w_br, w_dst, w_use_s, w_use_t;
    logic w_we, w_ld_use, w_ex_dep, w_mem_dep, w_haz, w_taken, w_issue;

    assign w_op   = instruction[31:26];
    assign w_fn   = instruction[5:0];
    assign w_rs5  = instruction[25:21];
    assign w_rt5  = instruction[20:16];
    assign w_rd5  = instruction[15:11];
    assign w_rs   = w_rs5[REG_AW-1:0];
    assign w_rt   = w_rt5[REG_AW-1:0];
    assign w_rd   = w_rd5[REG_AW-1:0];
    assign w_imm  = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    assign w_dest = w_jal ? '1 : w_dst ? w_rd : w_rt;

    // ALU op codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra
    always_comb begin
        case (w_fn)
            6'h20, 6'h21: w_r_aluop = 4'd0;
            6'h22, 6'h23: w_r_aluop = 4'd1;
            6'h24:        w_r_aluop = 4'd2;
            6'h25:        w_r_aluop = 4'd3;
            6'h26:        w_r_aluop = 4'd4;
            6'h27:        w_r_aluop = 4'd5;
            6'h2A:        w_r_aluop = 4'd6;
            6'h00:        w_r_aluop = 4'd7;
            6'h02:        w_r_aluop = 4'd8;
            6'h03:        w_r_aluop = 4'd9;
            default:      w_r_aluop = 4'd0;
        endcase
    end

    assign w_i_aluop = w_op == OP_SLTI ? 4'd6 : w_op == OP_ANDI ? 4'd2 :
                       w_op == OP_ORI  ? 4'd3 : w_op == OP_XORI ? 4'd4 : 4'd0;

    always_comb begin
        w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_m2r = 1'b0; w_src = 1'b0; w_jal = 1'b0;
        w_jmp = 1'b0; w_jr = 1'b0; w_br = 1'b0; w_dst = 1'b0; w_use_s = 1'b0; w_use_t = 1'b0;
        w_aluop = 4'd0;
        case (w_op)
            OP_R: begin
                w_use_s = 1'b1; w_use_t = 1'b1; w_dst = 1'b1;
                w_jr = w_fn == FN_JR; w_rw = w_fn != FN_JR; w_aluop = w_r_aluop;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                w_rw = 1'b1; w_src = 1'b1; w_use_s = 1'b1; w_aluop = w_i_aluop;
            end
            OP_LW: begin
                w_rw = 1'b1; w_mr = 1'b1; w_m2r = 1'b1; w_src = 1'b1; w_use_s = 1'b1;
            end
            OP_SW: begin
                w_mw = 1'b1; w_src = 1'b1; w_use_s = 1'b1; w_use_t = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_br = 1'b1; w_use_s = 1'b1; w_use_t = 1'b1; w_aluop = 4'd1;
            end
            OP_J: w_jmp = 1'b1;
            OP_JAL: begin
                w_jmp = 1'b1; w_jal = 1'b1; w_rw = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_waddr = wb_jal ? '1 : wb_addr;
    assign w_we    = wb_we && w_waddr != '0;
    assign w_rf1   = w_rs == '0 ? '0 : (w_we && w_waddr == w_rs) ? wb_data : r_regs[w_rs];
    assign w_rf2   = w_rt == '0 ? '0 : (w_we && w_waddr == w_rt) ? wb_data : r_regs[w_rt];
    // Non-load MEM results bypass the register file for the comparator and jr
    assign w_fwd1  = (mem_regwrite && !mem_memread && mem_dest == w_rs && w_rs != '0) ? mem_data : w_rf1;
    assign w_fwd2  = (mem_regwrite && !mem_memread && mem_dest == w_rt && w_rt != '0) ? mem_data : w_rf2;

    assign w_ld_use  = ex_valid && ex_MemReadEn && ex_dest != '0 &&
                       ((w_use_s && ex_dest == w_rs) || (w_use_t && ex_dest == w_rt));
    assign w_ex_dep  = ex_valid && ex_RegWriteEn && ex_dest != '0 &&
                       (ex_dest == w_rs || (w_br && ex_dest == w_rt));
    assign w_mem_dep = mem_memread && mem_dest != '0 && (mem_dest == w_rs || (w_br && mem_dest == w_rt));
    assign w_haz     = if_valid && (w_ld_use || ((w_br || w_jr) && (w_ex_dep || w_mem_dep)));
    assign w_taken   = w_jmp || w_jr || (w_br && ((w_fwd1 == w_fwd2) != w_op[0]));
    assign w_issue   = if_valid && !w_haz;

    assign id_ready        = !w_haz && !stall_in;
    assign redirect        = if_valid && id_ready && w_taken;
    assign redirect_target = w_jr ? w_fwd1[PC_W-1:0] : w_jmp ? instruction[PC_W-1:0] : PCPlus1 + w_imm[PC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[w_waddr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0; ex_RegWriteEn <= 1'b0; ex_MemReadEn <= 1'b0; ex_MemWriteEn <= 1'b0;
            ex_MemtoReg <= 1'b0; ex_ALUSrc <= 1'b0; ex_jal <= 1'b0; ex_ALUOp <= '0;
            ex_readData1 <= '0; ex_readData2 <= '0; ex_extImm <= '0;
            ex_rs <= '0; ex_rt <= '0; ex_dest <= '0; ex_shamt <= '0; ex_pcplus1 <= '0;
        end else if (!stall_in) begin
            ex_valid      <= w_issue;
            ex_RegWriteEn <= w_issue && w_rw;
            ex_MemReadEn  <= w_issue && w_mr;
            ex_MemWriteEn <= w_issue && w_mw;
            ex_MemtoReg   <= w_issue && w_m2r;
            ex_ALUSrc     <= w_issue && w_src;
            ex_jal        <= w_issue && w_jal;
            ex_ALUOp      <= w_issue ? w_aluop : '0;
            ex_readData1  <= w_haz ? '0 : w_rf1;
            ex_readData2  <= w_haz ? '0 : w_rf2;
            ex_extImm     <= w_haz ? '0 : w_imm;
            ex_rs         <= w_haz ? '0 : w_rs;
            ex_rt         <= w_haz ? '0 : w_rt;
            ex_dest       <= w_haz ? '0 : w_dest;
            ex_shamt      <= w_haz ? '0 : instruction[10:6];
            ex_pcplus1    <= w_haz ? '0 : PCPlus1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_count <= '0;
        else if (w_haz && !stall_in && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios plus randomized traffic checked against an
// instruction-level reference model of the decode stage.
module tb_decode_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid, stall_in, wb_we, wb_jal, mem_regwrite, mem_memread;
    logic [31:0] instruction, wb_data, mem_data;
    logic [9:0]  PCPlus1;
    logic [4:0]  wb_addr, mem_dest;
    logic        id_ready, redirect;
    logic [9:0]  redirect_target, ex_pcplus1;
    logic        ex_valid, ex_RegWriteEn, ex_MemReadEn, ex_MemWriteEn, ex_MemtoReg, ex_ALUSrc, ex_jal;
    logic [3:0]  ex_ALUOp;
    logic [31:0] ex_readData1, ex_readData2, ex_extImm;
    logic [4:0]  ex_rs, ex_rt, ex_dest, ex_shamt;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    decode_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .PCPlus1(PCPlus1),
        .stall_in(stall_in), .id_ready(id_ready), .wb_we(wb_we), .wb_jal(wb_jal), .wb_addr(wb_addr),
        .wb_data(wb_data), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_dest(mem_dest),
        .mem_data(mem_data), .redirect(redirect), .redirect_target(redirect_target), .ex_valid(ex_valid),
        .ex_RegWriteEn(ex_RegWriteEn), .ex_MemReadEn(ex_MemReadEn), .ex_MemWriteEn(ex_MemWriteEn),
        .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_jal(ex_jal), .ex_ALUOp(ex_ALUOp),
        .ex_readData1(ex_readData1), .ex_readData2(ex_readData2), .ex_extImm(ex_extImm), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_shamt(ex_shamt), .ex_pcplus1(ex_pcplus1),
        .stall_count(stall_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        bit rw, mr, mw, m2r, src, jal, jmp, jr, br, bne, use_s, use_t;
        bit [3:0] op;
        bit [4:0] dest;
    } dec_t;

    typedef struct packed {
        bit        v;
        dec_t      d;
        bit [31:0] a, b, imm;
        bit [4:0]  rs, rt, sh;
        bit [9:0]  pc;
    } ex_t;

    bit [31:0] m_reg [32];
    ex_t       m_ex;
    int        m_cnt;
    bit [5:0]  r_fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};

    function automatic bit [3:0] r_op(input bit [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 4'd0;
            6'h22, 6'h23: return 4'd1;
            6'h24: return 4'd2;
            6'h25: return 4'd3;
            6'h26: return 4'd4;
            6'h27: return 4'd5;
            6'h2A: return 4'd6;
            6'h00: return 4'd7;
            6'h02: return 4'd8;
            6'h03: return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    // Instruction meaning by mnemonic: what it writes, reads and how it steers fetch
    function automatic dec_t decode(input bit [31:0] ins);
        dec_t d;
        bit [5:0] op;
        d = '0;
        op = ins[31:26];
        d.dest = ins[20:16];
        case (op)
            6'h00: begin
                d.use_s = 1; d.use_t = 1; d.dest = ins[15:11];
                if (ins[5:0] == 6'h08) d.jr = 1;
                else begin d.rw = 1; d.op = r_op(ins[5:0]); end
            end
            6'h08: begin d.rw = 1; d.src = 1; d.use_s = 1; d.op = 4'd0; end
            6'h0A: begin d.rw = 1; d.src = 1; d.use_s = 1; d.op = 4'd6; end
            6'h0C: begin d.rw = 1; d.src = 1; d.use_s = 1; d.op = 4'd2; end
            6'h0D: begin d.rw = 1; d.src = 1; d.use_s = 1; d.op = 4'd3; end
            6'h0E: begin d.rw = 1; d.src = 1; d.use_s = 1; d.op = 4'd4; end
            6'h23: begin d.rw = 1; d.mr = 1; d.m2r = 1; d.src = 1; d.use_s = 1; end
            6'h2B: begin d.mw = 1; d.src = 1; d.use_s = 1; d.use_t = 1; end
            6'h04, 6'h05: begin d.br = 1; d.bne = op[0]; d.use_s = 1; d.use_t = 1; d.op = 4'd1; end
            6'h02: d.jmp = 1;
            6'h03: begin d.jmp = 1; d.jal = 1; d.rw = 1; d.dest = 5'd31; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic bit [31:0] rf(input bit [4:0] a);
        bit [4:0] wa;
        wa = wb_jal ? 5'd31 : wb_addr;
        if (a == 0) return 32'd0;
        if (wb_we && wa == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit [31:0] fw(input bit [4:0] a);
        return (mem_regwrite && !mem_memread && mem_dest == a && a != 0) ? mem_data : rf(a);
    endfunction

    function automatic bit hits(input bit [4:0] r, input bit [4:0] rs, input bit [4:0] rt, input bit br);
        return r != 0 && (r == rs || (br && r == rt));
    endfunction

    function automatic bit hazard();
        dec_t d;
        bit [4:0] rs, rt;
        bit lu, dep;
        d = decode(instruction);
        rs = instruction[25:21];
        rt = instruction[20:16];
        if (!if_valid) return 0;
        lu = m_ex.v && m_ex.d.mr && m_ex.d.dest != 0 &&
             ((d.use_s && m_ex.d.dest == rs) || (d.use_t && m_ex.d.dest == rt));
        dep = (m_ex.v && m_ex.d.rw && hits(m_ex.d.dest, rs, rt, d.br)) || (mem_memread && hits(mem_dest, rs, rt, d.br));
        return lu || ((d.br || d.jr) && dep);
    endfunction

    task automatic model_reset();
        m_ex = '0;
        m_cnt = 0;
        foreach (m_reg[i]) m_reg[i] = 32'd0;
    endtask

    task automatic check_comb();
        dec_t d;
        bit h, taken, exp_r;
        bit [31:0] a, b;
        bit [9:0] tgt;
        d = decode(instruction);
        h = hazard();
        a = fw(instruction[25:21]);
        b = fw(instruction[20:16]);
        taken = d.jmp || d.jr || (d.br && ((a == b) != d.bne));
        tgt = d.jr ? a[9:0] : d.jmp ? instruction[9:0] : PCPlus1 + instruction[9:0];
        exp_r = if_valid && !h && !stall_in && taken;
        check("id_ready", 32'(id_ready), 32'(!h && !stall_in));
        check("redirect", 32'(redirect), 32'(exp_r));
        if (exp_r) check("redirect_target", 32'(redirect_target), 32'(tgt));
    endtask

    task automatic model_edge();
        dec_t d;
        ex_t n;
        bit h;
        bit [4:0] wa;
        d = decode(instruction);
        h = hazard();
        wa = wb_jal ? 5'd31 : wb_addr;
        if (!stall_in) begin
            if (h) begin
                m_ex = '0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                n = '0;
                n.v = if_valid;
                if (if_valid) n.d = d;
                n.d.dest = d.dest;
                n.a = rf(instruction[25:21]);
                n.b = rf(instruction[20:16]);
                n.imm = {{16{instruction[15]}}, instruction[15:0]};
                n.rs = instruction[25:21];
                n.rt = instruction[20:16];
                n.sh = instruction[10:6];
                n.pc = PCPlus1;
                m_ex = n;
            end
        end
        if (wb_we && wa != 0) m_reg[wa] = wb_data;
    endtask

    task automatic check_regs();
        check("ex_valid", 32'(ex_valid), 32'(m_ex.v));
        check("ex_RegWriteEn", 32'(ex_RegWriteEn), 32'(m_ex.d.rw));
        check("ex_MemReadEn", 32'(ex_MemReadEn), 32'(m_ex.d.mr));
        check("ex_MemWriteEn", 32'(ex_MemWriteEn), 32'(m_ex.d.mw));
        check("ex_MemtoReg", 32'(ex_MemtoReg), 32'(m_ex.d.m2r));
        check("ex_ALUSrc", 32'(ex_ALUSrc), 32'(m_ex.d.src));
        check("ex_jal", 32'(ex_jal), 32'(m_ex.d.jal));
        check("ex_ALUOp", 32'(ex_ALUOp), 32'(m_ex.d.op));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
        if (m_ex.v) begin
            check("ex_readData1", ex_readData1, m_ex.a);
            check("ex_readData2", ex_readData2, m_ex.b);
            check("ex_extImm", ex_extImm, m_ex.imm);
            check("ex_rs", 32'(ex_rs), 32'(m_ex.rs));
            check("ex_rt", 32'(ex_rt), 32'(m_ex.rt));
            check("ex_dest", 32'(ex_dest), 32'(m_ex.d.dest));
            check("ex_shamt", 32'(ex_shamt), 32'(m_ex.sh));
            check("ex_pcplus1", 32'(ex_pcplus1), 32'(m_ex.pc));
        end
    endtask

    task automatic step();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic set_idle();
        if_valid = 0; instruction = 0; PCPlus1 = 0; stall_in = 0;
        wb_we = 0; wb_jal = 0; wb_addr = 0; wb_data = 0;
        mem_regwrite = 0; mem_memread = 0; mem_dest = 0; mem_data = 0;
    endtask

    task automatic issue(input bit [31:0] ins, input bit [9:0] pc);
        set_idle();
        if_valid = 1; instruction = ins; PCPlus1 = pc;
    endtask

    function automatic bit [31:0] rtype(input bit [4:0] rs, rt, rd, sh, input bit [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic bit [31:0] itype(input bit [5:0] op, input bit [4:0] rs, rt, input bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit [31:0] rnd_data();
        return $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    endfunction

    function automatic bit [31:0] rand_ins();
        bit [4:0] rs, rt, rd;
        bit [15:0] imm;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 11))
            0, 1: return rtype(rs, rt, rd, 5'($urandom), r_fns[$urandom_range(0, 9)]);
            2: return rtype(rs, 0, 0, 0, 6'h08);
            3: return itype(6'h08, rs, rt, imm);
            4: return itype(6'h0D, rs, rt, imm);
            5, 6: return itype(6'h23, rs, rt, imm);
            7: return itype(6'h2B, rs, rt, imm);
            8: return itype(6'h04, rs, rt, imm);
            9: return itype(6'h05, rs, rt, imm);
            10: return {6'h02, 26'($urandom)};
            default: return {6'h03, 26'($urandom)};
        endcase
    endfunction

    initial begin
        set_idle();
        model_reset();
        #12;
        check_regs();
        @(negedge clk);
        rst = 0;

        // Preload r1=10, r2=20, r4=4, r5=0x55
        foreach (r_fns[i]) if (i < 4) begin
            set_idle();
            wb_we = 1;
            wb_addr = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : (i == 2) ? 5'd4 : 5'd5;
            wb_data = (i == 0) ? 32'd10 : (i == 1) ? 32'd20 : (i == 2) ? 32'd4 : 32'h55;
            step();
        end

        // Load-use: lw r2,0(r1) ; add r3,r2,r4
        issue(itype(6'h23, 1, 2, 0), 10'h001);
        step();
        issue(rtype(2, 4, 3, 0, 6'h20), 10'h002);
        #1 check("lu_id_ready", 32'(id_ready), 32'd0);
        step();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_stall_count", 32'(stall_count), 32'd1);
        step();
        check("lu_issue", 32'(ex_valid), 32'd1);
        check("lu_rd1", ex_readData1, 32'd20);

        // Write-through of r7 while decoding add r8,r7,r0
        issue(rtype(7, 0, 8, 0, 6'h20), 10'h003);
        wb_we = 1; wb_addr = 7; wb_data = 32'h1234;
        step();
        check("wt_rd1", ex_readData1, 32'h1234);

        // beq r1,r2,+5 with r1 forwarded from MEM, target wraps
        issue(itype(6'h04, 1, 2, 16'd5), 10'h3FE);
        mem_regwrite = 1; mem_dest = 1; mem_data = 32'd20;
        #1 check("br_redirect", 32'(redirect), 32'd1);
        check("br_target", 32'(redirect_target), 32'h003);
        step();

        // jal 0x155, then link write through wb_jal
        issue({6'h03, 26'h155}, 10'h020);
        #1 check("jal_target", 32'(redirect_target), 32'h155);
        step();
        check("jal_ex_jal", 32'(ex_jal), 32'd1);
        check("jal_pcplus1", 32'(ex_pcplus1), 32'h020);
        set_idle();
        wb_we = 1; wb_jal = 1; wb_addr = 5; wb_data = 32'hCAFE;
        step();
        issue(rtype(31, 5, 9, 0, 6'h20), 10'h021);
        step();
        check("link_r31", ex_readData1, 32'hCAFE);
        check("link_r5_kept", ex_readData2, 32'h55);

        // Freeze during a load-use hazard
        issue(itype(6'h23, 1, 6, 0), 10'h030);
        step();
        issue(rtype(6, 0, 10, 0, 6'h20), 10'h031);
        stall_in = 1;
        #1 check("frz_id_ready", 32'(id_ready), 32'd0);
        step();
        check("frz_hold_mr", 32'(ex_MemReadEn), 32'd1);
        check("frz_hold_dest", 32'(ex_dest), 32'd6);
        check("frz_count", 32'(stall_count), 32'd1);
        stall_in = 0;
        step();
        check("frz_bubble_count", 32'(stall_count), 32'd2);
        step();

        // Reset mid-stall clears state without a clock edge
        issue(itype(6'h23, 1, 3, 0), 10'h040);
        step();
        issue(rtype(3, 3, 11, 0, 6'h20), 10'h041);
        #1 rst = 1;
        #1 check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_mr", 32'(ex_MemReadEn), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);
        model_reset();
        #1 rst = 0;
        step();
        issue(rtype(5, 0, 12, 0, 6'h20), 10'h042);
        step();
        check("rst_r5_zero", ex_readData1, 32'd0);

        for (int c = 0; c < 400; c++) begin
            if_valid = $urandom_range(0, 7) != 0;
            instruction = rand_ins();
            PCPlus1 = 10'($urandom);
            stall_in = $urandom_range(0, 7) == 0;
            wb_we = 1'($urandom_range(0, 1));
            wb_jal = $urandom_range(0, 9) == 0;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = rnd_data();
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_memread = $urandom_range(0, 3) == 0;
            mem_dest = 5'($urandom_range(0, 7));
            mem_data = rnd_data();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
